// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared types and constants for the fetch sequencer.
// Holds the sequencer state encoding, counter widths and default parameters.
package pc_ctrl_pkg;

    // Fetch sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_WAIT_RSP = 3'd2,
        ST_HOLD     = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_FLUSH    = 3'd5,
        ST_ERROR    = 3'd6
    } pc_state_e;

    // Width of the flush down-counter (FLUSH_DEPTH up to 7)
    localparam int unsigned PC_CTRL_FLUSH_W = 3;
    // Width of the imem wait counter (MAX_WAIT up to 255)
    localparam int unsigned PC_CTRL_WAIT_W = 8;

    // Default parameter values
    localparam int unsigned PC_CTRL_FLUSH_DEPTH_DEF = 2;
    localparam int unsigned PC_CTRL_MAX_WAIT_DEF    = 15;

    // True in the states that are waiting for an imem response word
    function automatic logic is_wait_state(input pc_state_e st);
        return (st == ST_WAIT_RSP) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/pc_ctrl_timer.sv
// pc_ctrl_timer: imem response wait counter.
// Counts cycles without a response while enabled; expired_o flags the cycle
// that is the MAX_WAIT-th consecutive cycle without a response.
module pc_ctrl_timer
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = PC_CTRL_MAX_WAIT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [PC_CTRL_WAIT_W-1:0] LAST = PC_CTRL_WAIT_W'(MAX_WAIT - 1);
    localparam logic [PC_CTRL_WAIT_W-1:0] ONE  = PC_CTRL_WAIT_W'(1);

    logic [PC_CTRL_WAIT_W-1:0] cnt_q;
    logic [PC_CTRL_WAIT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up while enabled and not at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // The current cycle without a response is the last one allowed
    assign expired_o = en_i && (cnt_q == LAST);

    // Wait counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch sequencer for the program-counter block.
// Runs the imem req/gnt/rvalid handshake with one request outstanding,
// holds the PC on decode hazards and redirects/squashes on taken branches.
// All control outputs are decoded from the state and same-cycle inputs.
// Optional feature: define PC_CTRL_STALL_CNT_EN to add the stall_cnt_o
// saturating counter of stalled cycles outside IDLE and ERROR.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH = PC_CTRL_FLUSH_DEPTH_DEF,
    parameter int unsigned MAX_WAIT    = PC_CTRL_MAX_WAIT_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        imem_req_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic        hazard_i,
    input  logic        branch_taken_i,
    output logic        stall_o,
    output logic        incr_pc_o,
    output logic        load_arith_o,
    output logic        flush_o,
    output logic        instr_valid_o,
    output logic        timeout_o
`ifdef PC_CTRL_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    localparam logic [PC_CTRL_FLUSH_W-1:0] FLUSH_LOAD  = PC_CTRL_FLUSH_W'(FLUSH_DEPTH - 1);
    localparam logic [PC_CTRL_FLUSH_W-1:0] FLUSH_ONE   = PC_CTRL_FLUSH_W'(1);
    localparam logic                       MULTI_FLUSH = (FLUSH_DEPTH > 1);

    pc_state_e                  state_q;
    pc_state_e                  state_d;
    logic [PC_CTRL_FLUSH_W-1:0] flush_cnt_q;
    logic [PC_CTRL_FLUSH_W-1:0] flush_cnt_d;

    logic redirect_s;
    logic outstanding_s;
    logic timer_clr_s;
    logic timer_en_s;
    logic expired_s;

    // A taken branch only redirects while actively fetching
    assign redirect_s = branch_taken_i &&
                        ((state_q == ST_REQ) || (state_q == ST_WAIT_RSP) || (state_q == ST_HOLD));

    // A granted request whose word has not come back must be drained after a redirect
    assign outstanding_s = ((state_q == ST_WAIT_RSP) && !imem_rvalid_i) ||
                           ((state_q == ST_REQ) && imem_gnt_i);

    // Timer runs only while waiting for a word; restarted whenever a wait begins
    assign timer_en_s  = is_wait_state(state_q) && !imem_rvalid_i;
    assign timer_clr_s = !is_wait_state(state_q) || redirect_s;

    pc_ctrl_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (timer_clr_s),
        .en_i      (timer_en_s),
        .expired_o (expired_s)
    );

    // Next-state and Mealy output decode
    always_comb begin
        state_d       = state_q;
        stall_o       = 1'b1;
        incr_pc_o     = 1'b0;
        load_arith_o  = 1'b0;
        flush_o       = 1'b0;
        instr_valid_o = 1'b0;
        imem_req_o    = 1'b0;
        timeout_o     = 1'b0;

        if (redirect_s) begin
            // Branch overrides everything else this cycle
            load_arith_o = 1'b1;
            stall_o      = 1'b0;
            flush_o      = 1'b1;
            if (outstanding_s) begin
                state_d = ST_DRAIN;
            end else if (MULTI_FLUSH) begin
                state_d = ST_FLUSH;
            end else begin
                state_d = ST_REQ;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    imem_req_o = 1'b1;
                    if (imem_gnt_i) begin
                        state_d = ST_WAIT_RSP;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_WAIT_RSP: begin
                    if (imem_rvalid_i) begin
                        instr_valid_o = 1'b1;
                        if (!hazard_i) begin
                            stall_o   = 1'b0;
                            incr_pc_o = 1'b1;
                            state_d   = ST_REQ;
                        end else begin
                            state_d = ST_HOLD;
                        end
                    end else if (expired_s) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_WAIT_RSP;
                    end
                end
                ST_HOLD: begin
                    instr_valid_o = 1'b1;
                    if (!hazard_i) begin
                        stall_o   = 1'b0;
                        incr_pc_o = 1'b1;
                        state_d   = ST_REQ;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    // The returning word belongs to the squashed path and is dropped
                    flush_o = 1'b1;
                    if (imem_rvalid_i) begin
                        if (flush_cnt_q > FLUSH_ONE) begin
                            state_d = ST_FLUSH;
                        end else begin
                            state_d = ST_REQ;
                        end
                    end else if (expired_s) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_FLUSH: begin
                    flush_o = 1'b1;
                    if (flush_cnt_q <= FLUSH_ONE) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
                ST_ERROR: begin
                    timeout_o = 1'b1;
                    state_d   = ST_ERROR;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Flush counter: loaded on redirect, otherwise decrements to zero
    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (redirect_s) begin
            flush_cnt_d = FLUSH_LOAD;
        end else if (flush_cnt_q != '0) begin
            flush_cnt_d = flush_cnt_q - FLUSH_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

`ifdef PC_CTRL_STALL_CNT_EN
    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    // Count stalled cycles while the sequencer is active, saturating at the top
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (state_q != ST_IDLE) && (state_q != ST_ERROR) &&
            (stall_cnt_q != STALL_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: self-checking bench for pc_ctrl with default parameters.
// A transaction-level model (run/pending/holding/discard flags plus a
// remaining-flush count) predicts every output each cycle; directed
// scenarios add hand-computed pulse counts and point checks.
module tb_pc_ctrl;

    localparam int FD = 2;
    localparam int MW = 15;

    logic clk = 1'b0;
    logic rst_i;
    logic start_i, imem_gnt_i, imem_rvalid_i, hazard_i, branch_taken_i;
    logic imem_req_o, stall_o, incr_pc_o, load_arith_o, flush_o, instr_valid_o, timeout_o;
`ifdef PC_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    pc_ctrl #(.FLUSH_DEPTH(FD), .MAX_WAIT(MW)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .imem_req_o     (imem_req_o),
        .imem_gnt_i     (imem_gnt_i),
        .imem_rvalid_i  (imem_rvalid_i),
        .hazard_i       (hazard_i),
        .branch_taken_i (branch_taken_i),
        .stall_o        (stall_o),
        .incr_pc_o      (incr_pc_o),
        .load_arith_o   (load_arith_o),
        .flush_o        (flush_o),
        .instr_valid_o  (instr_valid_o),
        .timeout_o      (timeout_o)
`ifdef PC_CTRL_STALL_CNT_EN
        ,
        .stall_cnt_o    (stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state
    bit m_run, m_err, m_pend, m_hold, m_disc;
    int m_fleft, m_waitc;
    logic [31:0] m_scnt;
    logic e_req, e_stall, e_incr, e_load, e_flush, e_valid, e_to;
    bit active;

    // Observed pulse counters for the directed scenarios
    int c_incr, c_valid, c_flush, c_load;

    // Per-cycle model step and comparison, on the falling edge
    always @(negedge clk) begin
        if (rst_i) begin
            m_run = 0; m_err = 0; m_pend = 0; m_hold = 0; m_disc = 0;
            m_fleft = 0; m_waitc = 0; m_scnt = 32'd0;
        end else begin
            e_req = 0; e_stall = 1; e_incr = 0; e_load = 0; e_flush = 0; e_valid = 0; e_to = 0;
            active = m_run && !m_err;
            if (m_err) begin
                e_to = 1;
            end else if (!m_run) begin
                if (start_i) m_run = 1;
            end else if (m_disc) begin
                e_flush = 1;
                if (m_fleft > 0) m_fleft--;
                if (imem_rvalid_i) m_disc = 0;
                else begin
                    m_waitc++;
                    if (m_waitc == MW) m_err = 1;
                end
            end else if (m_fleft > 0) begin
                e_flush = 1;
                m_fleft--;
            end else if (branch_taken_i) begin
                e_load = 1; e_stall = 0; e_flush = 1;
                if ((m_pend && !imem_rvalid_i) || (!m_pend && !m_hold && imem_gnt_i)) begin
                    m_disc = 1;
                    m_waitc = 0;
                end
                m_pend = 0; m_hold = 0; m_fleft = FD - 1;
            end else if (m_hold) begin
                e_valid = 1;
                if (!hazard_i) begin e_stall = 0; e_incr = 1; m_hold = 0; end
            end else if (m_pend) begin
                if (imem_rvalid_i) begin
                    e_valid = 1; m_pend = 0;
                    if (!hazard_i) begin e_stall = 0; e_incr = 1; end
                    else m_hold = 1;
                end else begin
                    m_waitc++;
                    if (m_waitc == MW) m_err = 1;
                end
            end else begin
                e_req = 1;
                if (imem_gnt_i) begin m_pend = 1; m_waitc = 0; end
            end
            check("imem_req_o",    32'(imem_req_o),    32'(e_req));
            check("stall_o",       32'(stall_o),       32'(e_stall));
            check("incr_pc_o",     32'(incr_pc_o),     32'(e_incr));
            check("load_arith_o",  32'(load_arith_o),  32'(e_load));
            check("flush_o",       32'(flush_o),       32'(e_flush));
            check("instr_valid_o", 32'(instr_valid_o), 32'(e_valid));
            check("timeout_o",     32'(timeout_o),     32'(e_to));
`ifdef PC_CTRL_STALL_CNT_EN
            check("stall_cnt_o",   stall_cnt_o,        m_scnt);
`endif
            if (active && e_stall && (m_scnt != 32'hFFFF_FFFF)) m_scnt = m_scnt + 32'd1;
            c_incr  += int'(incr_pc_o);
            c_valid += int'(instr_valid_o);
            c_flush += int'(flush_o);
            c_load  += int'(load_arith_o);
        end
    end

    task automatic set_in(input logic s, input logic g, input logic r, input logic h, input logic b);
        start_i = s; imem_gnt_i = g; imem_rvalid_i = r; hazard_i = h; branch_taken_i = b;
    endtask

    task automatic step(input logic s, input logic g, input logic r, input logic h, input logic b);
        set_in(s, g, r, h, b);
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        c_incr = 0; c_valid = 0; c_flush = 0; c_load = 0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        set_in(0, 0, 0, 0, 0);
        clr_counts();
        @(posedge clk); #1;
        do_reset();

        // Reset state
        set_in(0, 0, 0, 0, 0); #1;
        check("reset_stall",   32'(stall_o),    32'd1);
        check("reset_req",     32'(imem_req_o), 32'd0);
        check("reset_timeout", 32'(timeout_o),  32'd0);
        check("reset_flush",   32'(flush_o),    32'd0);

        // Start: request appears the following cycle
        @(posedge clk); #1;
        step(1, 0, 0, 0, 0);
        set_in(0, 0, 0, 0, 0); #1;
        check("req_after_start", 32'(imem_req_o), 32'd1);

        // Four back-to-back fetches at 1-cycle latency
        clr_counts();
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0, 0);
            step(0, 0, 1, 0, 0);
        end
        check("fetch4_incr",  32'(c_incr),  32'd4);
        check("fetch4_valid", 32'(c_valid), 32'd4);

        // Hazard with the returning word, held three more cycles
        clr_counts();
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        set_in(0, 0, 0, 0, 0); #1;
        check("hold_release_incr",  32'(incr_pc_o), 32'd1);
        check("hold_release_stall", 32'(stall_o),   32'd0);
        @(posedge clk); #1;
        check("hold_valid_cnt", 32'(c_valid), 32'd5);
        check("hold_incr_cnt",  32'(c_incr),  32'd1);

        // Branch while waiting, word returns two cycles later
        clr_counts();
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check("drain_load_cnt",  32'(c_load),  32'd1);
        check("drain_flush_cnt", 32'(c_flush), 32'd3);
        check("drain_valid_cnt", 32'(c_valid), 32'd0);
        set_in(0, 0, 0, 0, 0); #1;
        check("drain_then_req", 32'(imem_req_o), 32'd1);
        @(posedge clk); #1;

        // Branch while holding: two flush cycles, request on the third
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        clr_counts();
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);
        set_in(0, 0, 0, 0, 0); #1;
        check("hold_br_req3",  32'(imem_req_o), 32'd1);
        check("hold_br_flush", 32'(c_flush),    32'd2);
        @(posedge clk); #1;

        // Branch together with the returning word: no drain, word dropped
        step(0, 1, 0, 0, 0);
        clr_counts();
        step(0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0);
        set_in(0, 0, 0, 0, 0); #1;
        check("br_rvalid_req",   32'(imem_req_o), 32'd1);
        check("br_rvalid_valid", 32'(c_valid),    32'd0);
        check("br_rvalid_flush", 32'(c_flush),    32'd2);

        // Branch in REQ with grant: drain the granted request
        clr_counts();
        step(0, 1, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        set_in(0, 0, 0, 0, 0); #1;
        check("req_br_gnt_req",   32'(imem_req_o), 32'd1);
        check("req_br_gnt_flush", 32'(c_flush),    32'd2);
        @(posedge clk); #1;

        // Reset mid-request: late word is ignored in IDLE
        step(0, 1, 0, 0, 0);
        rst_i = 1'b1;
        step(0, 0, 0, 0, 0);
        rst_i = 1'b0;
        clr_counts();
        step(0, 0, 1, 0, 0);
        set_in(0, 0, 0, 0, 0); #1;
        check("late_rvalid_valid", 32'(c_valid),    32'd0);
        check("idle_after_reset",  32'(imem_req_o), 32'd0);
        @(posedge clk); #1;

        // Timeout after MW cycles without a response
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < MW - 1; i++) step(0, 0, 0, 0, 0);
        set_in(0, 0, 0, 0, 0); #1;
        check("timeout_not_yet", 32'(timeout_o), 32'd0);
        @(posedge clk); #1;
        set_in(0, 0, 0, 0, 0); #1;
        check("timeout_set",   32'(timeout_o), 32'd1);
        check("timeout_stall", 32'(stall_o),   32'd1);
        @(posedge clk); #1;
        step(0, 0, 0, 0, 1);
        set_in(0, 0, 0, 0, 0); #1;
        check("timeout_sticky", 32'(timeout_o), 32'd1);
        @(posedge clk); #1;
        do_reset();
        set_in(0, 0, 0, 0, 0); #1;
        check("timeout_cleared", 32'(timeout_o), 32'd0);
        @(posedge clk); #1;

`ifdef PC_CTRL_STALL_CNT_EN
        // Ten fetches at 1-cycle latency: one stalled REQ cycle each
        do_reset();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 0, 0);
            step(0, 0, 1, 0, 0);
        end
        set_in(0, 0, 0, 0, 0); #1;
        check("stall_cnt_10", stall_cnt_o, 32'd10);
        @(posedge clk); #1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
